reducer_accumulator: RTL

- Consumer-side counterpart of the mapper stage in the MrSim MapReduce pipeline.
- Accepts a stream of 64-bit key/value words from the mapper output FIFO.
- Sums values over runs of consecutive equal keys and emits one {key, sum} word per run toward the encode/output FIFO.
- Sits inside the controller in place of (or after) the mapper.

---
 rtl/reducer_accumulator_if.sv | 27 ++
 rtl/reducer_accumulator.sv | 103 ++++++++++
 2 files changed

// File: rtl/reducer_accumulator_if.sv
// Stream bundle for the reducer: key/value words in, {key, sum} words out,
// plus the end-of-stream flush and status outputs.
interface reducer_accumulator_if #(
    parameter int KEY_W = 32,
    parameter int VAL_W = 32,
    parameter int CNT_W = 16
);
    logic [KEY_W+VAL_W-1:0] io_rx_dat_int;
    logic                   io_rx_val;
    logic                   io_rx_rdy;
    logic                   io_flush;
    logic [KEY_W+VAL_W-1:0] io_tx_dat_int;
    logic                   io_tx_val;
    logic                   io_tx_rdy;
    logic                   io_busy;
    logic [CNT_W-1:0]       io_groups;

    modport master (
        output io_rx_dat_int, io_rx_val, io_flush, io_tx_rdy,
        input  io_rx_rdy, io_tx_dat_int, io_tx_val, io_busy, io_groups
    );

    modport slave (
        input  io_rx_dat_int, io_rx_val, io_flush, io_tx_rdy,
        output io_rx_rdy, io_tx_dat_int, io_tx_val, io_busy, io_groups
    );
endinterface

// File: rtl/reducer_accumulator.sv
// Sums values over runs of consecutive equal keys and emits one {key, sum}
// word per run through a single-entry output slot.
//
//   state | meaning
//   IDLE  | no pending run
//   ACCUM | acc_key/acc_sum hold the current run
module reducer_accumulator #(
    parameter int KEY_W = 32,
    parameter int VAL_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    reducer_accumulator_if.slave bus
);
    localparam int DAT_W = KEY_W + VAL_W;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   acc_key_q, acc_key_d;
    logic [VAL_W-1:0]   acc_sum_q, acc_sum_d;
    logic [DAT_W-1:0]   out_reg_q, out_reg_d;
    logic               out_full_q, out_full_d;
    logic [CNT_W-1:0]   groups_q, groups_d;

    logic               out_free;
    logic               rx_rdy;
    logic               rx_fire;
    logic               flush_fire;
    logic               tx_fire;
    logic [KEY_W-1:0]   rx_key;
    logic [VAL_W-1:0]   rx_val;

    assign rx_key = bus.io_rx_dat_int[DAT_W-1:VAL_W];
    assign rx_val = bus.io_rx_dat_int[VAL_W-1:0];

    always_comb begin
        out_free   = !out_full_q || bus.io_tx_rdy;
        // flush wins over rx, so the two fire conditions never overlap
        rx_rdy     = out_free && !bus.io_flush;
        rx_fire    = bus.io_rx_val && rx_rdy;
        flush_fire = bus.io_flush && out_free;
        tx_fire    = out_full_q && bus.io_tx_rdy;

        state_d    = state_q;
        acc_key_d  = acc_key_q;
        acc_sum_d  = acc_sum_q;
        out_reg_d  = out_reg_q;
        out_full_d = out_full_q;
        groups_d   = groups_q;

        if (tx_fire) begin
            out_full_d = 1'b0;
            groups_d   = groups_q + CNT_W'(1);
        end

        if (flush_fire) begin
            if (state_q == ACCUM) begin
                out_reg_d  = {acc_key_q, acc_sum_q};
                out_full_d = 1'b1;
                state_d    = IDLE;
            end
        end else if (rx_fire) begin
            if (state_q == IDLE) begin
                acc_key_d = rx_key;
                acc_sum_d = rx_val;
                state_d   = ACCUM;
            end else if (rx_key == acc_key_q) begin
                acc_sum_d = acc_sum_q + rx_val;
            end else begin
                out_reg_d  = {acc_key_q, acc_sum_q};
                out_full_d = 1'b1;
                acc_key_d  = rx_key;
                acc_sum_d  = rx_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_key_q  <= '0;
            acc_sum_q  <= '0;
            out_reg_q  <= '0;
            out_full_q <= 1'b0;
            groups_q   <= '0;
        end else begin
            state_q    <= state_d;
            acc_key_q  <= acc_key_d;
            acc_sum_q  <= acc_sum_d;
            out_reg_q  <= out_reg_d;
            out_full_q <= out_full_d;
            groups_q   <= groups_d;
        end
    end

    assign bus.io_rx_rdy     = rx_rdy;
    assign bus.io_tx_dat_int = out_reg_q;
    assign bus.io_tx_val     = out_full_q;
    assign bus.io_busy       = (state_q == ACCUM) || out_full_q;
    assign bus.io_groups     = groups_q;
endmodule
